// File: rtl/operand_pkg.sv
// Shared definitions for the operand SRAM path: widths, sequencer states and
// the SRAM read/write encoding used by the loader, the fetcher and the datapath.
package operand_pkg;

    localparam int A_WIDTH = 15;
    localparam int D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_e;

    localparam logic SRAM_READ = 1'b0;

endpackage

// File: rtl/operand_fetch_if.sv
// SRAM read port plus the valid/ready operand stream driven by operand_fetch.
// master = the fetcher; slave = the SRAM model and downstream consumer.
interface operand_fetch_if #(
    parameter int A_WIDTH = operand_pkg::A_WIDTH,
    parameter int D_WIDTH = operand_pkg::D_WIDTH
);
    logic [A_WIDTH-1:0] Sram_Addr;
    logic               Sram_En;
    logic               Sram_RW;
    logic [D_WIDTH-1:0] Sram_Data;
    logic [D_WIDTH-1:0] Op_Data;
    logic               Op_Valid;
    logic               Op_Ready;

    modport master (
        output Sram_Addr, Sram_En, Sram_RW,
        input  Sram_Data,
        output Op_Data, Op_Valid,
        input  Op_Ready
    );

    modport slave (
        input  Sram_Addr, Sram_En, Sram_RW,
        output Sram_Data,
        input  Op_Data, Op_Valid,
        output Op_Ready
    );
endinterface

// File: rtl/operand_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with occupancy count; DEPTH must be a power of two.
module operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count do, so it maps to plain RAM/regs.
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/operand_fetch.sv
// Read sequencer: issues Length byte reads from Base_Addr, absorbs the one-cycle
// SRAM latency and returns the bytes in order on a backpressured stream.
module operand_fetch #(
    parameter int A_WIDTH    = operand_pkg::A_WIDTH,
    parameter int D_WIDTH    = operand_pkg::D_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [A_WIDTH-1:0] Base_Addr,
    input  logic [A_WIDTH:0]   Length,
    output logic               Busy,
    output logic               Done,
    operand_fetch_if.master    bus
);
    import operand_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [A_WIDTH:0] LEN_ONE = (A_WIDTH+1)'(1);

    state_e             state_q, state_d;
    logic [A_WIDTH:0]   rem_q, rem_d;
    logic [A_WIDTH:0]   acc_q, acc_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic               sram_en_q, sram_en_d;
    logic               rd_pending_q, rd_pending_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [D_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full;
    logic               handshake;
    logic [1:0]         inflight;
    logic               can_issue;

    operand_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(D_WIDTH)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (rd_pending_q & ~fifo_full),
        .pop   (handshake),
        .din   (bus.Sram_Data),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign handshake = ~fifo_empty & bus.Op_Ready;
    // Reads on the SRAM bus or in its return cycle still own a FIFO slot; a pop this cycle frees nothing yet.
    assign inflight  = {1'b0, sram_en_q} + {1'b0, rd_pending_q};
    assign can_issue = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave it unassigned and infer a latch.
        state_d      = state_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        sram_en_d    = 1'b0;
        sram_addr_d  = '0;
        rd_pending_d = sram_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (handshake) acc_d = acc_q - LEN_ONE;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    busy_d = 1'b1;
                    acc_d  = Length;
                    if (Length == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        // The first read goes out on the Start edge itself, giving the 3-cycle latency.
                        sram_en_d   = 1'b1;
                        sram_addr_d = Base_Addr;
                        addr_d      = Base_Addr + A_WIDTH'(1);
                        rem_d       = Length - LEN_ONE;
                        state_d     = (Length == LEN_ONE) ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (can_issue) begin
                    sram_en_d   = 1'b1;
                    sram_addr_d = addr_q;
                    addr_d      = addr_q + A_WIDTH'(1);
                    rem_d       = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && acc_q == LEN_ONE) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            acc_q        <= '0;
            addr_q       <= '0;
            sram_addr_q  <= '0;
            sram_en_q    <= 1'b0;
            rd_pending_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            sram_addr_q  <= sram_addr_d;
            sram_en_q    <= sram_en_d;
            rd_pending_q <= rd_pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign bus.Sram_Addr = sram_addr_q;
    assign bus.Sram_En   = sram_en_q;
    assign bus.Sram_RW   = SRAM_READ;
    assign bus.Op_Valid  = ~fifo_empty;
    // The unreset FIFO array is masked so Op_Data reads 0 whenever nothing is buffered.
    assign bus.Op_Data   = fifo_empty ? '0 : fifo_head;

endmodule
